// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited sequential requests to imem,
// in-order responses buffered in a small prefetch FIFO, redirect and HALT.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  output logic              halted
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [3:0]  HALT_OP = 4'b1000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];

  logic gnt_fire_c;
  logic push_c;
  logic pop_c;

  // Next-state: redirect overrides everything; otherwise grant, response and pop
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    gnt_fire_c = req_q && imem_gnt;
    push_c     = imem_rvalid && (drop_q == '0) && !redirect_valid;
    pop_c      = (count_q != '0) && ir_ready && !redirect_valid;
    outst_d    = outst_q + CNT_W'(gnt_fire_c) - CNT_W'(imem_rvalid);

    if (redirect_valid) begin
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_d     = outst_d;
    end else begin
      if (gnt_fire_c) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (push_c) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + ADDR_W'(1);
        if (imem_rdata[DATA_W-1 -: 4] == HALT_OP) begin
          state_d = ST_HALTED;
        end
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end

    // Buffered plus in-flight words never exceed the FIFO depth
    req_d = (state_d == ST_RUN) &&
            ((SUM_W'(count_d) + SUM_W'(outst_d)) < SUM_W'(DEPTH));
  end

  // Control and FSM state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else if (push_c) begin
      fifo_data_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  // Credit accounting must never let a response land in a full FIFO
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_c && (count_q == CNT_W'(DEPTH)) && !pop_c));
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = fetch_pc_q;
  assign ir_valid  = (count_q != '0);
  assign ir_data   = fifo_data_q[rd_ptr_q];
  assign ir_pc     = fifo_pc_q[rd_ptr_q];
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural memory with random
// grant/latency and an expected-PC stream model on the decode side.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              ir_valid;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_ready;
  logic              halted;

  int checks;
  int failures;
  int cyc = 0;

  logic [DATA_W-1:0] mem_q [4096];

  // Memory model knobs (written by tests) and bookkeeping (written by memory)
  int gnt_pct = 100;
  int min_dly = 1;
  int max_dly = 1;
  int gnt_total = 0;
  logic [ADDR_W-1:0] last_gnt_addr = '0;

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } pend_t;
  pend_t pend_q[$];
  pend_t pend_new;
  int    last_due = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ir_valid       (ir_valid),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
    .ir_ready       (ir_ready),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: grants seen at negedge, in-order responses 1..N cycles later
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
      end else if (imem_req && imem_gnt) begin
        pend_new.due  = cyc + 1 + int'($urandom_range(max_dly, min_dly));
        if (pend_new.due <= last_due) pend_new.due = last_due + 1;
        last_due      = pend_new.due;
        pend_new.addr = imem_addr;
        pend_q.push_back(pend_new);
        gnt_total     = gnt_total + 1;
        last_gnt_addr = imem_addr;
      end
      @(posedge clk);
      #2;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (rst_n && (pend_q.size() > 0) && (pend_q[0].due == cyc + 1)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_q[pend_q[0].addr];
        void'(pend_q.pop_front());
      end
      imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) drive_edge();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for the next decode handshake; returns what was consumed
  task automatic wait_consume(output bit ok, output logic [ADDR_W-1:0] pc,
                              output logic [DATA_W-1:0] data);
    ok   = 1'b0;
    pc   = '0;
    data = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rst_n && !redirect_valid && ir_valid && ir_ready) begin
        ok   = 1'b1;
        pc   = ir_pc;
        data = ir_data;
        break;
      end
    end
  endtask

  task automatic issue_redirect(input logic [ADDR_W-1:0] tgt);
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    drive_edge();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) drive_edge();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
    checks++; if (imem_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL reset_ir_valid got=%0h exp=0", ir_valid); end
    checks++; if (ir_data !== '0) begin failures++; $display("FAIL reset_ir_data got=%0h exp=0", ir_data); end
    checks++; if (ir_pc !== '0) begin failures++; $display("FAIL reset_ir_pc got=%0h exp=0", ir_pc); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h exp=0", halted); end
  endtask

  task automatic test_straight();
    logic [DATA_W-1:0] exp_w [5];
    exp_w[0] = 32'h1900_0000; exp_w[1] = 32'h9900_0000; exp_w[2] = 32'h1900_1001;
    exp_w[3] = 32'h5900_1000; exp_w[4] = 32'h2900_0001;
    for (int i = 0; i < 5; i++) mem_q[i] = exp_w[i];
    gnt_pct = 100; min_dly = 1; max_dly = 1; ir_ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL straight_req_pre got=%0h exp=0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
      failures++; $display("FAIL straight_first_req got=%0h/%0h exp=1/000", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL straight_latency got=%0h exp=0", ir_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ir_valid !== 1'b1 || ir_pc !== 12'(i) || ir_data !== exp_w[i]) begin
        failures++;
        $display("FAIL straight_word%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, ir_valid, ir_pc, ir_data, i, exp_w[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g0;
    bit ok; logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] d;
    gnt_pct = 100; min_dly = 1; max_dly = 1; ir_ready = 1'b0;
    do_reset();
    g0 = gnt_total;
    repeat (10) @(negedge clk);
    checks++; if (gnt_total - g0 !== 4) begin failures++; $display("FAIL bp_grants got=%0d exp=4", gnt_total - g0); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_stop got=%0h exp=0", imem_req); end
    checks++; if (ir_valid !== 1'b1 || ir_pc !== 12'h000) begin
      failures++; $display("FAIL bp_head got=%0h/%0h exp=1/000", ir_valid, ir_pc); end
    drive_edge();
    ir_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_consume(ok, pc, d);
      checks++;
      if (!ok || pc !== 12'(i) || d !== mem_q[i]) begin
        failures++; $display("FAIL bp_drain%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, ok, pc, d, i, mem_q[i]);
      end
    end
  endtask

  task automatic test_redirect();
    int g0;
    bit ok; logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] d;
    gnt_pct = 100; min_dly = 4; max_dly = 4; ir_ready = 1'b0;
    do_reset();
    g0 = gnt_total;
    for (int i = 0; i < 20 && (gnt_total - g0) < 2; i++) drive_edge();
    gnt_pct = 0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h002) begin
      failures++; $display("FAIL redir_hold got=%0h/%0h exp=1/002", imem_req, imem_addr); end
    drive_edge();
    redirect_valid = 1'b1;
    redirect_pc    = 12'h020;
    drive_edge();
    redirect_valid = 1'b0;
    gnt_pct  = 100;
    ir_ready = 1'b1;
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0h exp=0", ir_valid); end
    for (int i = 0; i < 3; i++) begin
      wait_consume(ok, pc, d);
      checks++;
      if (!ok || pc !== 12'(32 + i) || d !== mem_q[32 + i]) begin
        failures++; $display("FAIL redir_word%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, ok, pc, d, 32 + i, mem_q[32 + i]);
      end
    end
  endtask

  task automatic test_halt();
    int g0, g_at, extra;
    bit ok; logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] saved;
    saved = mem_q[3];
    mem_q[3] = 32'h8000_0000;
    gnt_pct = 100; min_dly = 1; max_dly = 1; ir_ready = 1'b1;
    do_reset();
    g0 = gnt_total;
    for (int i = 0; i < 4; i++) begin
      wait_consume(ok, pc, d);
      checks++;
      if (!ok || pc !== 12'(i) || d !== mem_q[i]) begin
        failures++; $display("FAIL halt_word%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, ok, pc, d, i, mem_q[i]);
      end
    end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0h exp=1", halted); end
    g_at  = gnt_total;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (ir_valid && ir_ready) begin
        checks++;
        if (ir_pc !== 12'(4 + extra) || ir_data !== mem_q[4 + extra]) begin
          failures++; $display("FAIL halt_inflight got=%0h/%0h exp=%0h/%0h", ir_pc, ir_data, 4 + extra, mem_q[4 + extra]);
        end
        extra++;
      end
    end
    checks++; if (gnt_total - g_at !== 0 || imem_req !== 1'b0) begin
      failures++; $display("FAIL halt_no_req got=%0d/%0h exp=0/0", gnt_total - g_at, imem_req); end
    checks++; if ((4 + extra) !== (gnt_total - g0) || extra > int'(DEPTH)) begin
      failures++; $display("FAIL halt_count got=%0d exp=%0d", 4 + extra, gnt_total - g0); end
    checks++; if (last_gnt_addr < 12'h003 || last_gnt_addr > 12'(3 + DEPTH)) begin
      failures++; $display("FAIL halt_last_addr got=%0h exp=003..%0h", last_gnt_addr, 3 + DEPTH); end
    mem_q[3] = saved;
    issue_redirect(12'h000);
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_clear got=%0h exp=0", halted); end
    wait_consume(ok, pc, d);
    checks++; if (!ok || pc !== 12'h000 || d !== mem_q[0]) begin
      failures++; $display("FAIL halt_refetch got=%0h/%0h/%0h exp=1/000/%0h", ok, pc, d, mem_q[0]); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_pc [4];
    bit ok; logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] d;
    exp_pc[0] = 12'hFFE; exp_pc[1] = 12'hFFF; exp_pc[2] = 12'h000; exp_pc[3] = 12'h001;
    gnt_pct = 100; min_dly = 1; max_dly = 2; ir_ready = 1'b1;
    issue_redirect(12'hFFE);
    @(negedge clk);
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush got=%0h exp=0", ir_valid); end
    for (int i = 0; i < 4; i++) begin
      wait_consume(ok, pc, d);
      checks++;
      if (!ok || pc !== exp_pc[i] || d !== mem_q[exp_pc[i]]) begin
        failures++; $display("FAIL wrap_word%0d got=%0h/%0h/%0h exp=1/%0h/%0h", i, ok, pc, d, exp_pc[i], mem_q[exp_pc[i]]);
      end
    end
  endtask

  task automatic test_random_stall();
    logic [ADDR_W-1:0] exp_pc, pv_addr;
    logic pv_req, pv_gnt, pv_ok;
    int n_cons;
    gnt_pct = 30; min_dly = 1; max_dly = 4;
    do_reset();
    exp_pc = '0; pv_req = 1'b0; pv_gnt = 1'b0; pv_ok = 1'b0; pv_addr = '0; n_cons = 0;
    for (int c = 0; c < 400; c++) begin
      ir_ready       = ($urandom_range(3, 0) != 0);
      redirect_valid = 1'b0;
      if (c == 200) rst_n = 1'b0;
      if (c == 203) rst_n = 1'b1;
      if (rst_n && c > 10 && $urandom_range(39, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 12'($urandom);
      end
      @(negedge clk);
      if (pv_ok && pv_req && !pv_gnt) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== pv_addr) begin
          failures++; $display("FAIL rnd_hold c=%0d got=%0h/%0h exp=1/%0h", c, imem_req, imem_addr, pv_addr);
        end
      end
      if (c == 202) begin
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0 || ir_valid !== 1'b0 || ir_data !== '0 ||
            ir_pc !== '0 || halted !== 1'b0) begin
          failures++; $display("FAIL rnd_reset got=%0h/%0h/%0h/%0h/%0h/%0h exp=all0",
                               imem_req, imem_addr, ir_valid, ir_data, ir_pc, halted);
        end
      end
      if (c == 204) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
          failures++; $display("FAIL rnd_restart got=%0h/%0h exp=1/000", imem_req, imem_addr);
        end
      end
      if (rst_n && !redirect_valid && ir_valid && ir_ready) begin
        checks++;
        if (ir_pc !== exp_pc || ir_data !== mem_q[exp_pc]) begin
          failures++; $display("FAIL rnd_word c=%0d got=%0h/%0h exp=%0h/%0h", c, ir_pc, ir_data, exp_pc, mem_q[exp_pc]);
        end
        exp_pc = exp_pc + 12'd1;
        n_cons++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      if (!rst_n) exp_pc = '0;
      pv_req  = imem_req;
      pv_gnt  = imem_gnt;
      pv_addr = imem_addr;
      pv_ok   = rst_n && !redirect_valid;
      drive_edge();
    end
    checks++; if (n_cons < 20) begin failures++; $display("FAIL rnd_progress got=%0d exp>=20", n_cons); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ir_ready       = 1'b0;
    for (int i = 0; i < 4096; i++) mem_q[i] = {4'h3, 16'(i * 7 + 1), 12'(i)};
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_random_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
